uart_byte_packer_mm_writer: RTL and testbench

- Consumes the UART receive byte stream and packs it little-endian into 32-bit words.
- Writes the words as an Avalon-MM master into the single-port on-chip RAM (15-bit word address, 4-bit byteenable), which is used as a circular capture buffer.
- A partial word is flushed with partial byteenable on request or after an idle timeout, so software on the Nios side sees every received byte.
- Sits between the UART RX core and the on-chip memory slave in the Qsys system.

---
 rtl/uart_byte_packer_mm_writer.sv | 157 +++++++++++++++
 tb/tb_uart_byte_packer_mm_writer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_packer_mm_writer.sv
// Packs UART RX bytes little-endian into 32-bit words and writes them as an
// Avalon-MM master into a circular word buffer, flushing partial words on demand/idle.
module uart_byte_packer_mm_writer #(
  parameter int unsigned BASE_WORD    = 0,
  parameter int unsigned DEPTH_WORDS  = 17740,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush_req,
  input  logic        clr,
  output logic [14:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic [14:0] wr_ptr,
  output logic        wrapped
);

  localparam int unsigned AW = 15;
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE_WORD);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BASE_WORD + DEPTH_WORDS - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [31:0]   pack_q, pack_d;
  logic          clr_pend_q, clr_pend_d;
  logic          in_ready_d, avm_write_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [AW-1:0] ptr_d;
  logic          wrapped_d;
  logic          accept;
  logic [2:0]    cnt_new;
  logic          go_write;

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_FILL;
      count_q        <= 3'd0;
      idle_q         <= '0;
      pack_q         <= 32'd0;
      clr_pend_q     <= 1'b0;
      in_ready       <= 1'b1;
      avm_write      <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_byteenable <= 4'd0;
      avm_writedata  <= 32'd0;
      avm_address    <= BASE_ADDR;
      wr_ptr         <= BASE_ADDR;
      wrapped        <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      idle_q         <= idle_d;
      pack_q         <= pack_d;
      clr_pend_q     <= clr_pend_d;
      in_ready       <= in_ready_d;
      avm_write      <= avm_write_d;
      avm_chipselect <= avm_write_d;
      avm_byteenable <= be_d;
      avm_writedata  <= wdata_d;
      avm_address    <= ptr_d;
      wr_ptr         <= ptr_d;
      wrapped        <= wrapped_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idle_d      = idle_q;
    pack_d      = pack_q;
    clr_pend_d  = clr_pend_q;
    in_ready_d  = in_ready;
    avm_write_d = avm_write;
    be_d        = avm_byteenable;
    wdata_d     = avm_writedata;
    ptr_d       = wr_ptr;
    wrapped_d   = wrapped;
    accept      = 1'b0;
    cnt_new     = count_q;
    go_write    = 1'b0;

    if (state_q == S_FILL) begin
      if (clr) begin
        ptr_d     = BASE_ADDR;
        wrapped_d = 1'b0;
        count_d   = 3'd0;
        idle_d    = '0;
        pack_d    = 32'd0;
      end else begin
        accept  = in_valid && in_ready;
        cnt_new = count_q + 3'(accept);
        if (accept) pack_d[{count_q[1:0], 3'b000} +: 8] = in_data;
        count_d = cnt_new;
        if (accept || count_q == 3'd0) idle_d = '0;
        else if (idle_q != IDLE_MAX)   idle_d = idle_q + IW'(1);
        // A 4th byte always produces a full word; flush/timeout only adds partial words
        if (cnt_new == 3'd4) begin
          go_write = 1'b1;
          be_d     = 4'b1111;
        end else if (cnt_new != 3'd0 && (flush_req || idle_q == IDLE_MAX)) begin
          go_write = 1'b1;
          case (cnt_new)
            3'd1:    be_d = 4'b0001;
            3'd2:    be_d = 4'b0011;
            default: be_d = 4'b0111;
          endcase
        end
        if (go_write) begin
          state_d     = S_WRITE;
          avm_write_d = 1'b1;
          wdata_d     = pack_d;
          in_ready_d  = 1'b0;
        end
      end
    end else begin
      if (clr) clr_pend_d = 1'b1;
      if (!avm_waitrequest) begin
        state_d     = S_FILL;
        avm_write_d = 1'b0;
        be_d        = 4'd0;
        wdata_d     = 32'd0;
        count_d     = 3'd0;
        idle_d      = '0;
        pack_d      = 32'd0;
        in_ready_d  = 1'b1;
        clr_pend_d  = 1'b0;
        // A clear seen during the write replaces the pointer advance
        if (clr || clr_pend_q) begin
          ptr_d     = BASE_ADDR;
          wrapped_d = 1'b0;
        end else if (wr_ptr == LAST_ADDR) begin
          ptr_d     = BASE_ADDR;
          wrapped_d = 1'b1;
        end else begin
          ptr_d = wr_ptr + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_packer_mm_writer.sv
// Directed bench for uart_byte_packer_mm_writer: expected writes are queued by the
// stimulus and checked by a decoupled bus monitor; ring of 4 words, idle timeout 16.
module tb_uart_byte_packer_mm_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush_req = 1'b0;
  logic        clr = 1'b0;
  logic [14:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [14:0] wr_ptr;
  logic        wrapped;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  n_acc = 0;

  uart_byte_packer_mm_writer #(
    .BASE_WORD(0), .DEPTH_WORDS(4), .IDLE_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush_req(flush_req), .clr(clr),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .wr_ptr(wr_ptr), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t w;
    w.addr = a; w.data = d; w.be = be;
    exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic fl);
    int t = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
    flush_req = fl;
    tick();
    in_valid = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      send(tmp[7:0], 1'b0);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(in_ready && !avm_write) && t < 100) begin tick(); t++; end
    chk("idle_reached", 32'(in_ready && !avm_write), 32'd1);
  endtask

  task automatic wait_write();
    int t = 0;
    while (!avm_write && t < 60) begin tick(); t++; end
    chk("write_seen", 32'(avm_write), 32'd1);
  endtask

  // Bus monitor: pops expectations on accepted writes and checks stall stability
  task automatic monitor();
    logic stalled = 1'b0;
    wr_t  prev;
    wr_t  cur;
    wr_t  e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        cur.addr = avm_address; cur.data = avm_writedata; cur.be = avm_byteenable;
        if (stalled) begin
          chk("write_held", 32'(avm_write), 32'd1);
          chk("stall_stable", 32'(cur == prev), 32'd1);
        end
        if (avm_write) begin
          chk("chipselect", 32'(avm_chipselect), 32'd1);
          chk("in_ready_low", 32'(in_ready), 32'd0);
          if (!avm_waitrequest) begin
            n_acc++;
            if (exp_q.size() == 0) begin
              chk("unexpected_write_addr", 32'(avm_address), 32'h7fff_ffff);
            end else begin
              e = exp_q.pop_front();
              chk("wr_addr", 32'(cur.addr), 32'(e.addr));
              chk("wr_data", cur.data, e.data);
              chk("wr_be", 32'(cur.be), 32'(e.be));
            end
          end
        end
        stalled = avm_write && avm_waitrequest;
        prev = cur;
      end
    end
  endtask

  initial begin
    int acc0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_be", 32'(avm_byteenable), 32'd0);
    chk("rst_wdata", avm_writedata, 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    reset_n = 1'b1;
    tick();

    // Full word, then latency check
    expect_wr(15'd0, 32'h4433_2211, 4'b1111);
    send4(32'h4433_2211);
    chk("write_latency", 32'(avm_write), 32'd1);
    tick();
    chk("ready_back", 32'(in_ready), 32'd1);
    wait_idle();
    chk("ptr_after_w0", 32'(wr_ptr), 32'd1);

    // Idle-timeout partial flush, then next byte on lane 0 of next word
    expect_wr(15'd1, 32'h0000_BBAA, 4'b0011);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    wait_write();
    wait_idle();
    chk("ptr_after_timeout", 32'(wr_ptr), 32'd2);
    expect_wr(15'd2, 32'hFFEE_DDCC, 4'b1111);
    send4(32'hFFEE_DDCC);
    wait_idle();

    // Stalled write; flush_req during the stall must be ignored; wrap at last word
    avm_waitrequest = 1'b1;
    expect_wr(15'd3, 32'h0403_0201, 4'b1111);
    send4(32'h0403_0201);
    acc0 = n_acc;
    flush_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush_req = 1'b0;
    end
    avm_waitrequest = 1'b0;
    wait_idle();
    repeat (3) tick();
    chk("stall_one_accept", 32'(n_acc - acc0), 32'd1);
    chk("ptr_wrapped", 32'(wr_ptr), 32'd0);
    chk("wrapped_set", 32'(wrapped), 32'd1);

    // flush_req with the 4th byte gives one full word only
    expect_wr(15'd0, 32'h0D0C_0B0A, 4'b1111);
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b0);
    send(8'h0C, 1'b0);
    send(8'h0D, 1'b1);
    wait_idle();
    repeat (4) tick();
    chk("ptr_after_coinc", 32'(wr_ptr), 32'd1);

    // flush_req with nothing buffered issues no write
    acc0 = n_acc;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (5) tick();
    chk("empty_flush_no_write", 32'(n_acc - acc0), 32'd0);

    // Explicit partial flush of 3 bytes
    expect_wr(15'd1, 32'h00C3_B2A1, 4'b0111);
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_write();
    wait_idle();

    // Fill through the wrap point again
    expect_wr(15'd2, 32'h1312_1110, 4'b1111);
    send4(32'h1312_1110);
    expect_wr(15'd3, 32'h1716_1514, 4'b1111);
    send4(32'h1716_1514);
    expect_wr(15'd0, 32'h1B1A_1918, 4'b1111);
    send4(32'h1B1A_1918);
    wait_idle();
    chk("ptr_before_clr", 32'(wr_ptr), 32'd1);
    chk("wrapped_before_clr", 32'(wrapped), 32'd1);

    // clr in FILL discards the partial byte and the coincident byte
    send(8'hEE, 1'b0);
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h99;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_ptr", 32'(wr_ptr), 32'd0);
    chk("clr_wrapped", 32'(wrapped), 32'd0);
    expect_wr(15'd0, 32'h5566_7788, 4'b1111);
    send4(32'h5566_7788);
    wait_idle();

    // clr during a stalled write takes effect on acceptance
    avm_waitrequest = 1'b1;
    expect_wr(15'd1, 32'h2423_2221, 4'b1111);
    send4(32'h2423_2221);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    chk("clr_pend_ptr_hold", 32'(wr_ptr), 32'd1);
    avm_waitrequest = 1'b0;
    wait_idle();
    chk("clr_pend_ptr", 32'(wr_ptr), 32'd0);
    chk("clr_pend_wrapped", 32'(wrapped), 32'd0);

    // Move the pointer, then reset asynchronously in the middle of a stalled write
    expect_wr(15'd0, 32'h2827_2625, 4'b1111);
    send4(32'h2827_2625);
    wait_idle();
    avm_waitrequest = 1'b1;
    send4(32'h3433_3231);
    chk("pre_reset_write", 32'(avm_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_write_drop", 32'(avm_write), 32'd0);
    chk("async_cs_drop", 32'(avm_chipselect), 32'd0);
    chk("async_ptr", 32'(wr_ptr), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    avm_waitrequest = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    expect_wr(15'd0, 32'h4443_4241, 4'b1111);
    send4(32'h4443_4241);
    wait_idle();
    chk("ptr_after_reset_word", 32'(wr_ptr), 32'd1);

    repeat (5) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
